// File: rtl/fir_out_fifo_if.sv
// Handshake bundle between the DA FIR output stage and its consumer.
// The master side drives samples in and ready back; the slave side is the FIFO.
interface fir_out_fifo_if #(
  parameter int IN_W  = 10,
  parameter int OUT_W = 8,
  parameter int DEPTH = 8
);
  localparam int CW = $clog2(DEPTH) + 1;

  logic                    in_valid;
  logic signed [IN_W-1:0]  y_in;
  logic                    out_ready;
  logic                    ovf_clr;
  logic                    out_valid;
  logic signed [OUT_W-1:0] out_data;
  logic [CW-1:0]           count;
  logic                    ovf;
  logic                    sat;

  modport master (
    output in_valid, y_in, out_ready, ovf_clr,
    input  out_valid, out_data, count, ovf, sat
  );

  modport slave (
    input  in_valid, y_in, out_ready, ovf_clr,
    output out_valid, out_data, count, ovf, sat
  );
endinterface

// File: rtl/fir_out_fifo.sv
// Round/saturate stage plus first-word-fall-through FIFO behind the DA FIR.
// Drops and flags samples on overflow since the filter cannot be stalled.
module fir_out_fifo #(
  parameter int IN_W  = 10,
  parameter int OUT_W = 8,
  parameter int SHIFT = 2,
  parameter int DEPTH = 8
) (
  input  logic         clk,
  input  logic         rst,
  fir_out_fifo_if.slave bus
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam int TW = IN_W + 1;
  localparam logic signed [TW-1:0] HALF    = TW'(2 ** (SHIFT - 1));
  localparam logic signed [TW-1:0] SAT_MAX = TW'(2 ** (OUT_W - 1) - 1);
  localparam logic signed [TW-1:0] SAT_MIN = TW'(-(2 ** (OUT_W - 1)));

  logic signed [TW-1:0]    w_t;
  logic signed [TW-1:0]    w_r;
  logic signed [OUT_W-1:0] w_conv;
  logic                    w_clip;

  // Round half toward +inf, then clip into the output range.
  always_comb begin
    w_t    = {bus.y_in[IN_W-1], bus.y_in} + HALF;
    w_r    = w_t >>> SHIFT;
    w_clip = 1'b1;
    if (w_r > SAT_MAX) begin
      w_conv = SAT_MAX[OUT_W-1:0];
    end else if (w_r < SAT_MIN) begin
      w_conv = SAT_MIN[OUT_W-1:0];
    end else begin
      w_conv = w_r[OUT_W-1:0];
      w_clip = 1'b0;
    end
  end

  logic [AW-1:0]           r_wr_ptr;
  logic [AW-1:0]           r_rd_ptr;
  logic [CW-1:0]           r_count;
  logic signed [OUT_W-1:0] r_mem [DEPTH];
  logic signed [OUT_W-1:0] r_out_data;
  logic                    r_ovf;
  logic                    r_sat;

  logic          w_full;
  logic          w_valid;
  logic          w_pop;
  logic          w_push;
  logic          w_drop;
  logic [AW-1:0] w_rd_next;
  logic [CW-1:0] w_remain;

  assign w_full    = (r_count == CW'(DEPTH));
  assign w_valid   = (r_count != '0);
  assign w_pop     = w_valid & bus.out_ready;
  assign w_push    = bus.in_valid & (~w_full | w_pop);
  assign w_drop    = bus.in_valid & w_full & ~w_pop;
  assign w_rd_next = r_rd_ptr + AW'(w_pop);
  assign w_remain  = r_count - CW'(w_pop);

  always_ff @(posedge clk) begin
    if (w_push && !rst) begin
      r_mem[r_wr_ptr] <= w_conv;
    end
  end

  // Head register: next entry from storage, or the incoming sample when it
  // becomes the only entry; held when the FIFO goes empty.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_out_data <= '0;
    end else if (w_remain != '0) begin
      r_out_data <= r_mem[w_rd_next];
    end else if (w_push) begin
      r_out_data <= w_conv;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      r_ovf    <= 1'b0;
      r_sat    <= 1'b0;
    end else begin
      r_wr_ptr <= r_wr_ptr + AW'(w_push);
      r_rd_ptr <= w_rd_next;
      r_count  <= r_count + CW'(w_push) - CW'(w_pop);
      r_sat    <= w_push & w_clip;
      if (w_drop) begin
        r_ovf <= 1'b1;
      end else if (bus.ovf_clr) begin
        r_ovf <= 1'b0;
      end
    end
  end

  assign bus.out_valid = w_valid;
  assign bus.out_data  = r_out_data;
  assign bus.count     = r_count;
  assign bus.ovf       = r_ovf;
  assign bus.sat       = r_sat;
endmodule

// File: tb/tb_fir_out_fifo.sv
// Scoreboard bench for fir_out_fifo: directed samples with hand-computed
// expected outputs, checked by a monitor on the falling edge.
module tb_fir_out_fifo;
  localparam int DEPTH = 8;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #50 clk = ~clk;

  fir_out_fifo_if #(.IN_W(10), .OUT_W(8), .DEPTH(DEPTH)) bus ();

  fir_out_fifo #(.IN_W(10), .OUT_W(8), .SHIFT(2), .DEPTH(DEPTH)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_checks = 0;
  int n_fail   = 0;
  logic signed [7:0] exp_q[$];
  logic signed [7:0] e;
  logic m_ovf  = 1'b0;
  logic mon_en = 1'b0;
  logic prev_hold = 1'b0;
  logic signed [31:0] prev_data = 0;

  task automatic chk(input string name, input logic signed [31:0] act,
                     input logic signed [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: pops the scoreboard whenever the consumer takes the head.
  always @(negedge clk) begin
    if (mon_en) begin
      chk("out_valid", bus.out_valid, exp_q.size() != 0);
      if (prev_hold && bus.out_valid)
        chk("hold", $signed(bus.out_data), prev_data);
      prev_hold = bus.out_valid && !bus.out_ready;
      prev_data = $signed(bus.out_data);
      if (exp_q.size() != 0 && bus.out_ready) begin
        e = exp_q.pop_front();
        $display("pop: out_data=%0d expected=%0d count=%0d", $signed(bus.out_data), e, bus.count);
        chk("out_data", $signed(bus.out_data), e);
      end
    end
  end

  // One clock of stimulus; eo/es are the hand-computed output and clip flag.
  task automatic step(input logic v, input logic signed [9:0] y, input logic rdy,
                      input logic clr, input logic signed [7:0] eo, input logic es);
    logic pop, full, acc;
    bus.in_valid = v;
    bus.y_in = y;
    bus.out_ready = rdy;
    bus.ovf_clr = clr;
    pop  = (exp_q.size() != 0) && rdy;
    full = (exp_q.size() == DEPTH);
    acc  = v && (!full || pop);
    if (v && full && !pop) m_ovf = 1'b1;
    else if (clr) m_ovf = 1'b0;
    @(posedge clk);
    #1;
    if (acc) exp_q.push_back(eo);
    chk("count", bus.count, exp_q.size());
    chk("ovf", bus.ovf, m_ovf);
    chk("sat", bus.sat, acc && es);
  endtask

  task automatic do_reset(input logic v, input logic signed [9:0] y);
    rst = 1'b1;
    bus.in_valid = v;
    bus.y_in = y;
    bus.out_ready = 1'b0;
    bus.ovf_clr = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b0;
    exp_q.delete();
    m_ovf = 1'b0;
    mon_en = 1'b1;
    chk("rst_count", bus.count, 0);
    chk("rst_out_valid", bus.out_valid, 0);
    chk("rst_ovf", bus.ovf, 0);
    chk("rst_out_data", $signed(bus.out_data), 0);
    chk("rst_sat", bus.sat, 0);
  endtask

  task automatic drain(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 10'sd0, 1'b1, 1'b0, 8'sd0, 1'b0);
  endtask

  initial begin
    bus.in_valid = 1'b0;
    bus.y_in = '0;
    bus.out_ready = 1'b0;
    bus.ovf_clr = 1'b0;
    do_reset(1'b0, 10'sd0);

    // Rounding: 5->1, 6->2, -6->-1, 0->0
    step(1'b1, 10'sd5,  1'b1, 1'b0, 8'sd1,  1'b0);
    step(1'b1, 10'sd6,  1'b1, 1'b0, 8'sd2,  1'b0);
    step(1'b1, -10'sd6, 1'b1, 1'b0, -8'sd1, 1'b0);
    step(1'b1, 10'sd0,  1'b1, 1'b0, 8'sd0,  1'b0);
    drain(2);

    // Saturation: 511 clips to 127; -512 lands exactly on -128
    step(1'b1, 10'sd511,  1'b1, 1'b0, 8'sd127,  1'b1);
    step(1'b1, -10'sd512, 1'b1, 1'b0, -8'sd128, 1'b0);
    drain(2);

    // Fill with 0,4..32 (outputs 0..8); the ninth is dropped
    for (int i = 0; i < 9; i++)
      step(1'b1, 10'(4 * i), 1'b0, 1'b0, 8'(i), 1'b0);

    // Full with simultaneous push/pop: 40..52 -> 10..13, no drop
    for (int k = 0; k < 4; k++)
      step(1'b1, 10'(40 + 4 * k), 1'b1, 1'b0, 8'(10 + k), 1'b0);
    drain(10);
    step(1'b0, 10'sd0, 1'b1, 1'b1, 8'sd0, 1'b0);

    // Wrap-around across three pointer laps
    for (int i = 0; i < 3 * DEPTH; i++)
      step(1'b1, 10'(4 * i), 1'b1, 1'b0, 8'(i), 1'b0);
    drain(2);

    // Refill, then drop with ovf_clr in the same cycle (set wins)
    for (int i = 0; i < DEPTH; i++)
      step(1'b1, 10'(4 * i + 2), 1'b0, 1'b0, 8'(i + 1), 1'b0);
    step(1'b1, 10'sd100, 1'b0, 1'b1, 8'sd25, 1'b0);
    for (int i = 0; i < 3; i++)
      step(1'b0, 10'sd0, 1'b1, 1'b0, 8'sd0, 1'b0);
    step(1'b0, 10'sd0, 1'b0, 1'b0, 8'sd0, 1'b0);
    chk("pre_rst_count", bus.count, 5);
    chk("pre_rst_ovf", bus.ovf, 1);

    // Reset mid-operation with a sample present; it must not appear
    do_reset(1'b1, 10'sd100);
    step(1'b1, 10'sd20, 1'b1, 1'b0, 8'sd5, 1'b0);
    drain(3);

    bus.in_valid = 1'b0;
    bus.out_ready = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/fir_out_fifo.md
# fir_out_fifo

Output stage placed directly downstream of the DA FIR filter. Captures each 10-bit signed `y_out` sample on a valid strobe, rounds and saturates it to 8 bits, and buffers it in a first-word-fall-through FIFO drained by a valid/ready consumer. Overflow is flagged rather than stalling, because the filter has no backpressure input.

## Interface
- `IN_W`, 10: width of the signed filter output sample.
- `OUT_W`, 8: width of the signed buffered sample.
- `SHIFT`, 2: right-shift applied before saturation; must satisfy 1 ≤ SHIFT < IN_W.
- `DEPTH`, 8: number of FIFO entries; must be a power of 2, at least 2.

- `clk`, in, 1: single clock; all logic updates on the rising edge.
- `rst`, in, 1: synchronous, active-high reset.
- `in_valid`, in, 1: a new filter sample is present this cycle.
- `y_in`, in, IN_W: signed filter output, driven from DA `y_out`.
- `out_ready`, in, 1: the consumer accepts `out_data` this cycle.
- `ovf_clr`, in, 1: clears the sticky `ovf` flag.
- `out_valid`, out, 1: the FIFO head is valid.
- `out_data`, out, OUT_W: signed FIFO head sample.
- `count`, out, log2(DEPTH)+1: current number of entries.
- `ovf`, out, 1: sticky flag; a sample was dropped while the FIFO was full.
- `sat`, out, 1: one-cycle pulse; the sample written this cycle was clipped.

## Operation
- **Conversion** is combinational on `y_in`:
  - `t = y_in + 2^(SHIFT-1)`, computed at IN_W+1 bits signed.
  - `r = t >>> SHIFT`, arithmetic shift (round half toward +∞).
  - Saturate `r` to [-2^(OUT_W-1), 2^(OUT_W-1)-1].
  - `sat` is asserted when clipping occurred.
- **Push**: `in_valid` and (not full, or pop this cycle) → the converted sample is written at `wr_ptr`, and `wr_ptr` increments, wrapping mod DEPTH.
- **Pop**: `out_valid` and `out_ready` → `rd_ptr` increments, wrapping mod DEPTH.
- **Full with pop**: simultaneous push and pop while full → both are accepted; `count` is unchanged and stays DEPTH.
- **Empty with push**: simultaneous push and pop while empty → a pop is impossible (`out_valid` is 0), so only the push takes effect.
- **Drop**: `in_valid` while full with no pop → the sample is discarded, pointers do not change, and `ovf` is set to 1.
- **`ovf` clearing**:
  - `ovf` stays set until `ovf_clr` or `rst`.
  - If `ovf_clr` and a new drop happen in the same cycle, `ovf` stays 1 (set wins).
- **`sat` gating**: `sat` pulses only for samples actually written; dropped samples do not assert `sat`.
- **Head output**: `out_data` always shows the entry at `rd_ptr` (first-word fall-through). When `out_valid` is 0, `out_data` is held at its last value.
- **Reset** (`rst` = 1 at a clock edge), including mid-operation:
  - Pointers, `count`, `ovf`, `sat` and `out_valid` go to 0; `out_data` goes to 0.
  - Buffered samples are lost.
  - Any `in_valid` in the reset cycle is ignored.

## Timing
- **Write-to-output latency**: a sample pushed at edge N into an empty FIFO gives `out_valid` = 1 and `out_data` = converted value after edge N (visible in cycle N+1).
- **`count`**: registered; reflects pushes and pops of edge N after that edge.
- **Full condition**: `count` == DEPTH. Empty condition: `count` == 0.
- **`sat`**: registered; asserted for exactly the cycle after the edge that wrote the clipped sample.
- **Throughput**: one push and one pop per cycle are sustainable indefinitely.
- **Consumer rule**: the consumer may hold `out_ready` high permanently. `out_data` must not change while `out_valid` = 1 and `out_ready` = 0.
- **Upstream rate**: the filter produces one sample per 100 ns clock. `in_valid` may be tied high; the FIFO then fills only if the consumer stalls.

## Test plan
- **Reset and rounding**: `rst` 1 for 1 cycle, then `out_ready` = 1; push `y_in` = 5, 6, -6, 0 on consecutive cycles → `out_data` = 1, 2, -1, 0, each one cycle after its push; `sat` stays 0; `count` stays ≤ 1.
- **Saturation**: push `y_in` = 511 then -512 → `out_data` = 127 with `sat` pulse, then -128 with no `sat` pulse (-510 >>> 2 = -128 is in range).
- **Fill, overflow, drain**: `out_ready` = 0; push 0…8 (×4, so inputs 0, 4, …, 32) → `count` = 8 after the 8th push; the 9th push is dropped and `ovf` = 1. Then `out_ready` = 1 → outputs 0…7 in order, `count` reaches 0, `out_valid` drops, and `ovf` stays 1 until an `ovf_clr` pulse.
- **Full, simultaneous push/pop**: with the FIFO full, drive `in_valid` and `out_ready` together for 4 cycles with inputs 40, 44, 48, 52 → no drop, `count` stays 8, and `ovf` does not set. After draining, the last outputs are 10, 11, 12, 13, after the 4 remaining original entries.
- **Wrap-around**: run 3×DEPTH push/pop pairs with an incrementing input → the output sequence has no gaps or duplicates across pointer wrap.
- **Reset mid-operation**: with `count` = 5 and `ovf` = 1, assert `rst` together with `in_valid` → next cycle `count` = 0, `out_valid` = 0, `ovf` = 0, `out_data` = 0, and the reset-cycle sample is absent.
